nibble_serial_add_ctrl: RTL
===========================

Name: nibble_serial_add_ctrl

Overview:
Sequencer that performs a wide addition by driving one 4-bit adder slice (half/full-adder ripple with carry-in) once per cycle, least-significant nibble first. A carry register links the nibbles. Operands are 4*NIBBLES bits wide. The block sits between the lab datapath and the nibble adder and uses a start/busy/done handshake.

Parameters:
NIBBLES, 4, number of 4-bit slices per operation; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only when busy=0
a  input  W  operand A; captured on the accepting edge
b  input  W  operand B; captured on the accepting edge
sub  input  1  subtract select; present only with ADD_SUB_EN; captured with a/b
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse; marks sum/c_out as freshly valid
sum  output  W  result of the last completed operation
c_out  output  1  carry out of the top nibble of the last completed operation

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, sum=0, c_out=0; internal shift registers, carry and index cleared.
- States: IDLE, RUN.
- IDLE:
  - If start=1 at edge E0: latch a and b into shift registers; carry<=0 (or 1 when subtracting); idx<=0; partial-result register<=0; busy<=1; go to RUN.
  - Otherwise remain in IDLE.
- RUN, at edge E(i+1), i=0..NIBBLES-1:
  - Nibble sum = a_sh[3:0] + b_sh[3:0] + carry, using a 4-bit slice with a 5-bit result.
  - Low 4 bits are written to partial[4i+3:4i]; bit 4 goes to carry.
  - Shift registers shift right by 4; idx increments.
- Last nibble (idx=NIBBLES-1):
  - At the same edge E(NIBBLES): sum<=final partial, c_out<=final carry, done<=1, busy<=0, go to IDLE.
- Latency: done is high in the cycle following edge E(NIBBLES), i.e. NIBBLES edges after the accepting edge. busy is high for exactly NIBBLES cycles.
- done is deasserted on the next edge unless it is re-generated by a later operation. Because done is a pulse and busy is 0 in the done cycle, a start in the done cycle is accepted. Back-to-back throughput is one operation per NIBBLES+1 cycles.
- start while busy=1 is ignored; it is not queued. Changes to a/b/sub while busy have no effect.
- sum and c_out hold the last completed result. They change only at the completion edge, never mid-operation.
- Arithmetic is modulo 2^W. c_out is the true carry out of bit W-1. There are no overflow flags.
- NIBBLES=1: a single RUN cycle; done asserts 1 edge after acceptance.
- rst_n asserted mid-RUN: the operation is aborted; outputs are cleared immediately and no done is produced after release.

Optional Feature:
ADD_SUB_EN
- Defined:
  - The sub port exists and is captured at acceptance.
  - When sub=1, each b nibble is inverted before the slice and the initial carry is 1, giving a - b in two's complement.
  - c_out=1 means no borrow (a >= b unsigned).
  - When sub=0, behaviour is identical to the undefined build.
- Undefined: no sub port; addition only; initial carry is always 0.

Test Plan:
1. NIBBLES=4; a=0x1234, b=0x4321, start for 1 cycle -> busy=1 for 4 cycles; done pulses 4 edges after acceptance; sum=0x5555, c_out=0.
2. a=0xFFFF, b=0x0001 -> carry ripples through every nibble; sum=0x0000, c_out=1; sum stays at the previous value until the done edge.
3. start held high throughout, a/b changed mid-run -> first result unaffected (0x5555). Second operation accepted in the done cycle; second done exactly 5 cycles after the first.
4. rst_n driven low during the 2nd RUN cycle -> busy, done, sum and c_out read 0 immediately. After release with start=0: no done, state IDLE.
5. ADD_SUB_EN: sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, c_out=0. Then a=0x0007, b=0x0005 -> sum=0x0002, c_out=1.
6. NIBBLES=1; a=0x9, b=0x8 -> done 1 edge after acceptance; sum=0x1, c_out=1; busy high for 1 cycle.

Source files
------------

// File: rtl/nibble_serial_add_ctrl_if.sv
// ---------------------------------------------------------------------------
// nibble_serial_add_ctrl_if
//
// Purpose : start/busy/done handshake bundle between the lab datapath
//           (master) and the nibble-serial adder sequencer (slave).
//
// Signals :
//   start  master->slave  request, honoured only while busy=0
//   a, b   master->slave  W-bit operands, W = 4*NIBBLES
//   sub    master->slave  subtract select (only when ADD_SUB_EN is defined)
//   busy   slave->master  operation in progress
//   done   slave->master  one-cycle pulse, sum/c_out freshly valid
//   sum    slave->master  result of the last completed operation
//   c_out  slave->master  carry out of the top nibble
//
// Optional feature macro: ADD_SUB_EN (adds the sub signal).
// ---------------------------------------------------------------------------
interface nibble_serial_add_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
`ifdef ADD_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;

`ifdef ADD_SUB_EN
  modport master (
    output start, a, b, sub,
    input  busy, done, sum, c_out
  );

  modport slave (
    input  start, a, b, sub,
    output busy, done, sum, c_out
  );
`else
  modport master (
    output start, a, b,
    input  busy, done, sum, c_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, c_out
  );
`endif

endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_serial_add_ctrl
//
// Purpose : Wide adder built from a single 4-bit ripple slice. Operands are
//           captured on the accepting edge and fed through the slice one
//           nibble per cycle, least-significant nibble first, with a carry
//           register linking consecutive nibbles. The finished result and
//           carry out are published together with a one-cycle done pulse.
//
// Ports   :
//   clk    input   single clock, rising-edge
//   rst_n  input   asynchronous, active-low reset
//   bus    slave modport of nibble_serial_add_ctrl_if
//            start/a/b[/sub] in, busy/done/sum/c_out out
//
// Parameters:
//   NIBBLES  number of 4-bit slices per operation (1..16), W = 4*NIBBLES
//
// Optional feature macro: ADD_SUB_EN
//   Defined   : bus.sub is captured with the operands; sub=1 inverts each b
//               nibble and seeds the carry with 1, giving a - b. c_out=1
//               then means "no borrow" (a >= b unsigned).
//   Undefined : addition only, carry always seeded with 0.
// ---------------------------------------------------------------------------
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  nibble_serial_add_ctrl_if.slave bus
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;

  // Control strobes from the FSM.
  logic             accept;
  logic             step;
  logic             finish;

  // Operand shift registers, carry link, nibble index, result build-up.
  logic [W-1:0]     a_sh;
  logic [W-1:0]     b_sh;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     partial;
  logic [W-1:0]     partial_nxt;

  // Published result.
  logic [W-1:0]     sum_q;
  logic             c_out_q;
  logic             done_q;

  // Slice inputs/outputs.
  logic [3:0]       b_nib;
  logic [4:0]       nib_res;
  logic             carry_init;

`ifdef ADD_SUB_EN
  logic             sub_q;
`endif

  // 4-bit ripple of full adders; bit 4 of the result is the slice carry out.
  function automatic logic [4:0] slice_add(
    input logic [3:0] x,
    input logic [3:0] y,
    input logic       ci
  );
    logic [4:0] r;
    logic       c;
    r = '0;
    c = ci;
    for (int k = 0; k < 4; k++) begin
      r[k] = x[k] ^ y[k] ^ c;
      c    = (x[k] & y[k]) | (c & (x[k] ^ y[k]));
    end
    r[4] = c;
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next-state and control strobes
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (idx == LAST_IDX) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Slice operand selection and result insertion
  // -------------------------------------------------------------------------
  always_comb begin
`ifdef ADD_SUB_EN
    b_nib      = sub_q ? ~b_sh[3:0] : b_sh[3:0];
    carry_init = bus.sub;
`else
    b_nib      = b_sh[3:0];
    carry_init = 1'b0;
`endif
    nib_res     = slice_add(a_sh[3:0], b_nib, carry);
    partial_nxt = partial;
    // idx*4 selects the nibble currently leaving the slice.
    partial_nxt[{idx, 2'b00} +: 4] = nib_res[3:0];
  end

  // -------------------------------------------------------------------------
  // Datapath registers: operand capture, per-nibble step, completion
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      carry   <= 1'b0;
      idx     <= '0;
      partial <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef ADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      // done is a pulse; only the completion edge re-asserts it.
      done_q <= finish;
      if (accept) begin
        a_sh    <= bus.a;
        b_sh    <= bus.b;
        carry   <= carry_init;
        idx     <= '0;
        partial <= '0;
`ifdef ADD_SUB_EN
        sub_q   <= bus.sub;
`endif
      end else if (step) begin
        a_sh    <= a_sh >> 4;
        b_sh    <= b_sh >> 4;
        carry   <= nib_res[4];
        idx     <= idx + IDX_W'(1);
        partial <= partial_nxt;
      end
      // sum/c_out move only here, so they never show a half-built result.
      if (finish) begin
        sum_q   <= partial_nxt;
        c_out_q <= nib_res[4];
      end
    end
  end

  assign bus.busy  = (state == RUN);
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;

endmodule
